// File: rtl/program_loader.sv
// Byte-stream program loader: packs header/data/checksum frames into 16-bit
// words, writes them to instruction memory and releases run once the XOR checksum matches.
module program_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              run,
  output logic              err,
  output logic [8:0]        words_loaded
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HI    = 3'd1;
  localparam logic [2:0] S_LO    = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]        state;
  logic [8:0]        n_words;
  logic [7:0]        acc;
  logic [7:0]        hi;
  logic [ADDR_W-1:0] widx;
  logic              xfer;

  assign in_ready = (state != S_WRITE);
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      n_words      <= '0;
      acc          <= '0;
      hi           <= '0;
      widx         <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_wdata    <= '0;
      run          <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        // DONE and ERR hold their outputs but accept a new header like IDLE.
        S_IDLE, S_DONE, S_ERR: begin
          if (xfer) begin
            n_words      <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            acc          <= in_data;
            words_loaded <= '0;
            widx         <= '0;
            run          <= 1'b0;
            err          <= 1'b0;
            state        <= S_HI;
          end
        end
        S_HI: begin
          if (xfer) begin
            hi    <= in_data;
            acc   <= acc ^ in_data;
            state <= S_LO;
          end
        end
        S_LO: begin
          if (xfer) begin
            acc       <= acc ^ in_data;
            mem_wdata <= {hi, in_data};
            mem_addr  <= BASE_ADDR + widx;
            mem_we    <= 1'b1;
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          words_loaded <= words_loaded + 9'd1;
          widx         <= widx + 1'b1;
          state        <= (words_loaded + 9'd1 == n_words) ? S_CSUM : S_HI;
        end
        S_CSUM: begin
          if (xfer) begin
            if (in_data == acc) begin
              run   <= 1'b1;
              state <= S_DONE;
            end else begin
              err   <= 1'b1;
              state <= S_ERR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Write-side counterpart of the instruction fetch path. Receives a program image as a byte stream, packs bytes into 16-bit instruction words and writes them through the 256x16 instruction memory write port.
- Holds the processor via `run`=0 during a load. Releases it (`run`=1, used as the fetch enable) only after the checksum verifies.
- Sits between the host byte link (UART RX or testbench) and the instruction memory.

Parameters:
- ADDR_W, 8, instruction memory address width (256 words).
- BASE_ADDR, 0, address of the first word written; subsequent addresses increment modulo 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte; a transfer occurs when in_valid && in_ready at a rising edge.
- mem_we  output  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  16  write data.
- run  output  1  program loaded and verified; drives fetch enable.
- err  output  1  last load failed its checksum.
- words_loaded  output  9  words written in the current or last load.

Behaviour:
- Frame format: header byte N (0 means 256 words), then 2N data bytes (high byte first per word), then 1 checksum byte.
  - Checksum = XOR of the header and all data bytes.
- Reset (reset=0, asynchronous):
  - State = IDLE; `mem_we`, `run`, `err` = 0.
  - `mem_addr` = BASE_ADDR; `mem_wdata` = 0; `words_loaded` = 0.
  - Internal counters and XOR accumulator cleared.
  - Any partially received word is discarded and no write occurs.
- `in_ready` = 1 in every state except the cycle a write is issued (WRITE); no transfer is lost when `in_valid` is held.
- States:
  - IDLE: on transfer, latch N (0 maps to 256), acc = byte, `words_loaded` = 0, `run` = 0, `err` = 0 -> HI.
  - HI: on transfer, hold byte as high half, acc ^= byte -> LO.
  - LO: on transfer, acc ^= byte. Register `mem_wdata` = {hi, byte} and `mem_addr` = BASE_ADDR + word index. `mem_we` = 1 in the next cycle -> WRITE.
  - WRITE (one cycle, `mem_we`=1, `in_ready`=0): `words_loaded`++ and word index++. If `words_loaded` after increment equals N -> CSUM, else -> HI.
  - CSUM: on transfer, byte == acc -> DONE with `run`=1. Otherwise -> ERR with `err`=1, `run`=0.
  - DONE / ERR: outputs held. A new transfer is treated as a new header and behaves exactly as IDLE: clears `run`/`err` in the following cycle, starts a reload.
- Latency: `mem_we` asserts exactly 1 cycle after the LO-byte transfer edge. `run`/`err` assert 1 cycle after the checksum transfer edge.
- `mem_addr` wraps modulo 2^ADDR_W; a 256-word load with BASE_ADDR≠0 wraps through 0xFF->0x00.
- Words written before a checksum failure remain in memory; only `run` is withheld.
- Gaps in `in_valid` (any length) change nothing but timing. No timeout.
- `mem_addr`/`mem_wdata` hold their last values when `mem_we`=0.

Test Plan:
- Reset: drive reset=0 mid-cycle with clk stopped -> `run`=0, `err`=0, `mem_we`=0, `mem_addr`=0x00, `words_loaded`=0 immediately; after release `in_ready`=1.
- Basic load: bytes 02,12,34,56,78,0A back-to-back ->
  - writes (0x00, 0x1234) and (0x01, 0x5678), each `mem_we` one cycle;
  - `run`=1, `err`=0, `words_loaded`=2; `in_ready` low only during each write cycle.
- Bad checksum: same frame, last byte 0B -> both writes occur, `err`=1, `run`=0. A following correct frame clears `err` and sets `run`=1.
- Stalled stream: frame 01,AB,CD,67 (01^AB^CD^67=00? compute in bench) with 0-5 idle cycles between bytes -> single write (0x00, 0xABCD), `run`=1 iff checksum byte matches bench-computed XOR.
- Reset mid-load: send 03,11,22,33, then pulse reset=0 -> no further `mem_we`, `words_loaded`=0. A subsequent full 1-word frame loads correctly at address BASE_ADDR.
- Full/wrap: BASE_ADDR=0xFE, header 00, 512 data bytes plus correct checksum -> 256 writes, addresses FE,FF,00..FD, `words_loaded`=256, `run`=1.
